// File: rtl/keccak_digest_reader.sv
// Captures each new keccak digest on the rising edge of out_ready and streams it
// as NWORDS words, most-significant word first, over a valid/ready handshake.
module keccak_digest_reader #(
   parameter int DIGEST_W = 512,
   parameter int WORD_W   = 64,
   parameter int NWORDS   = 8
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic [DIGEST_W-1:0]         out,
   input  logic                        out_ready,
   output logic [WORD_W-1:0]           word_out,
   output logic                        word_valid,
   input  logic                        word_ready,
   output logic                        word_last,
   output logic [$clog2(NWORDS)-1:0]   word_index,
   output logic                        busy,
   output logic                        overrun,
   output logic [15:0]                 digest_count
);

   localparam int IDX_W = $clog2(NWORDS);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NWORDS - 1);

   typedef enum logic {IDLE, SEND} state_t;

   state_t                state_reg, state_next;
   logic                  rdy_q_reg;
   logic [DIGEST_W-1:0]   shadow_reg, shadow_next;
   logic [IDX_W-1:0]      idx_reg, idx_next;
   logic [15:0]           count_reg, count_next;
   logic                  overrun_reg, overrun_next;
   logic                  new_digest;
   logic [WORD_W-1:0]     words [NWORDS];

   // Word gi is the gi-th slice counting down from the MSB of the shadow.
   generate
      for (genvar gi = 0; gi < NWORDS; gi++) begin : g_words
         assign words[gi] = shadow_reg[DIGEST_W-1-gi*WORD_W -: WORD_W];
      end
   endgenerate

   // rdy_q resets high so a level already present across reset never captures.
   assign new_digest   = out_ready & ~rdy_q_reg;
   assign word_out     = words[idx_reg];
   assign overrun      = overrun_reg;
   assign digest_count = count_reg;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg   <= IDLE;
         rdy_q_reg   <= 1'b1;
         shadow_reg  <= '0;
         idx_reg     <= '0;
         count_reg   <= '0;
         overrun_reg <= 1'b0;
      end else begin
         state_reg   <= state_next;
         rdy_q_reg   <= out_ready;
         shadow_reg  <= shadow_next;
         idx_reg     <= idx_next;
         count_reg   <= count_next;
         overrun_reg <= overrun_next;
      end
   end

   always_comb begin
      state_next   = state_reg;
      shadow_next  = shadow_reg;
      idx_next     = idx_reg;
      count_next   = count_reg;
      overrun_next = overrun_reg;
      word_valid   = 1'b0;
      busy         = 1'b0;
      word_last    = 1'b0;
      word_index   = '0;
      case (state_reg)
         IDLE: begin
            if (new_digest) begin
               shadow_next = out;
               idx_next    = '0;
               state_next  = SEND;
            end
         end
         SEND: begin
            word_valid = 1'b1;
            busy       = 1'b1;
            word_last  = (idx_reg == LAST_IDX);
            word_index = idx_reg;
            // A digest arriving mid-stream is dropped; only the flag records it.
            if (new_digest)
               overrun_next = 1'b1;
            if (word_ready) begin
               if (idx_reg == LAST_IDX) begin
                  count_next = count_reg + 16'd1;
                  state_next = IDLE;
               end else begin
                  idx_next = idx_reg + IDX_W'(1);
               end
            end
         end
      endcase
   end

endmodule

// File: tb/tb_keccak_digest_reader.sv
// Bench for keccak_digest_reader: directed scenarios plus random traffic, checked
// every cycle against a queue-of-expected-words model of the stream.
module tb_keccak_digest_reader;

   logic          clk = 1'b0;
   logic          reset;
   logic [511:0]  out;
   logic          out_ready;
   logic [63:0]   word_out;
   logic          word_valid;
   logic          word_ready;
   logic          word_last;
   logic [2:0]    word_index;
   logic          busy;
   logic          overrun;
   logic [15:0]   digest_count;

   keccak_digest_reader #(.DIGEST_W(512), .WORD_W(64), .NWORDS(8)) dut (
      .clk          (clk),
      .reset        (reset),
      .out          (out),
      .out_ready    (out_ready),
      .word_out     (word_out),
      .word_valid   (word_valid),
      .word_ready   (word_ready),
      .word_last    (word_last),
      .word_index   (word_index),
      .busy         (busy),
      .overrun      (overrun),
      .digest_count (digest_count)
   );

   always #5 clk = ~clk;

   int            n_cmp = 0;
   int            n_bad = 0;
   logic [63:0]   exp_q [$];
   logic [15:0]   exp_count;
   logic          exp_overrun;
   logic          prev_rdy;
   logic          was_reset;

   task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference: a captured digest becomes eight queued words, popped on each accept.
   task automatic model_update();
      logic nd;
      if (reset) begin
         exp_q.delete();
         exp_count   = '0;
         exp_overrun = 1'b0;
         prev_rdy    = 1'b1;
         was_reset   = 1'b1;
      end else begin
         nd        = out_ready && !prev_rdy;
         prev_rdy  = out_ready;
         was_reset = 1'b0;
         if (exp_q.size() != 0) begin
            if (nd) exp_overrun = 1'b1;
            if (word_ready) begin
               void'(exp_q.pop_front());
               if (exp_q.size() == 0) begin
                  exp_count = exp_count + 16'd1;
                  $display("digest %0d streamed", exp_count);
               end
            end
         end else if (nd) begin
            for (int k = 0; k < 8; k++)
               exp_q.push_back(64'(out >> (64 * (7 - k))));
         end
      end
   endtask

   task automatic compare();
      logic v;
      v = (exp_q.size() != 0);
      check_value("valid",   word_valid,   v);
      check_value("busy",    busy,         v);
      check_value("overrun", overrun,      exp_overrun);
      check_value("count",   digest_count, exp_count);
      check_value("index",   word_index,   v ? 64'(8 - exp_q.size()) : 64'd0);
      if (v) begin
         check_value("word", word_out,  exp_q[0]);
         check_value("last", word_last, exp_q.size() == 1);
      end else begin
         check_value("last_idle", word_last, 1'b0);
      end
      if (was_reset)
         check_value("rst_word", word_out, 64'd0);
   endtask

   task automatic tick();
      @(posedge clk);
      model_update();
      #1;
      compare();
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic random_digest();
      for (int i = 0; i < 16; i++) out[32*i +: 32] = $urandom;
   endtask

   initial begin
      reset = 1'b1; out_ready = 1'b0; word_ready = 1'b1; out = '0;
      ticks(3);
      reset = 1'b0;
      ticks(6);

      // Single digest with words 0..7, ready always high.
      for (int k = 0; k < 8; k++) out[511-64*k -: 64] = 64'(k);
      out_ready = 1'b1;
      ticks(12);

      // Backpressure: ready alternates.
      out_ready = 1'b0; tick();
      out_ready = 1'b1;
      for (int i = 0; i < 20; i++) begin
         word_ready = (i % 2 == 0);
         tick();
      end
      word_ready = 1'b1;
      ticks(2);

      // Overrun: second edge during word 3 with a different digest.
      reset = 1'b1; tick(); reset = 1'b0;
      random_digest();
      out_ready = 1'b0; tick();
      out_ready = 1'b1; tick();
      ticks(2);
      out_ready = 1'b0; random_digest(); tick();
      out_ready = 1'b1; tick();
      ticks(10);
      check_value("overrun_final", overrun, 1'b1);
      check_value("count_final", digest_count, 16'd1);

      // Held level across reset release, then a real edge.
      out_ready = 1'b1; reset = 1'b1; tick(); reset = 1'b0;
      ticks(6);
      out_ready = 1'b0; random_digest(); tick();
      out_ready = 1'b1; ticks(12);

      // Reset while word 5 is presented.
      out_ready = 1'b0; random_digest(); tick();
      out_ready = 1'b1;
      for (int i = 0; i < 20; i++) begin
         if (exp_q.size() == 3) break;
         tick();
      end
      check_value("at_word5", word_index, 3'd5);
      reset = 1'b1; tick(); reset = 1'b0;
      out_ready = 1'b0; tick();
      out_ready = 1'b1; ticks(12);

      // Random traffic.
      for (int i = 0; i < 1500; i++) begin
         reset      = ($urandom_range(0, 199) == 0);
         word_ready = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 99) < 12) out_ready = ~out_ready;
         if ($urandom_range(0, 9) == 0) random_digest();
         tick();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
